norm_fma16: RTL and testbench

Multi-cycle normalization stage for the fma16 datapath. It sits between the significand adder and the rounding unit. It accepts an unnormalized sum magnitude, sign and signed biased exponent over a valid/ready handshake. It then shifts one bit per cycle until the value is a normalized half-precision significand, a subnormal, or an overflow. Finally it presents the truncated 10-bit fraction, 5-bit exponent and guard/round/sticky bits that the rounding unit consumes.

---
 rtl/norm_fma16.sv | 170 +++++++++++++++++
 tb/tb_norm_fma16.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/norm_fma16.sv
// norm_fma16: multi-cycle normalization stage between the fma16 significand adder and the
// rounding unit. Accepts an unnormalized magnitude with sign and signed biased exponent.
// Shifts one bit per cycle until the value is normal, subnormal or overflowed. Then presents
// the truncated fraction, exponent and guard/round/sticky bits.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready high only when idle)
//   sign_in, sum_in       sign and unsigned magnitude (bit SUMW-1 = 2, bit SUMW-2 = 1)
//   exp_in                7-bit two's-complement biased exponent (bias 15)
//   out_valid / out_ready output handshake
//   sign, frac, ex        registered sign, 10-bit fraction, 5-bit exponent
//   g, r, t               guard, round, sticky
//   of, zero              exponent overflow (infinity encoding), exact zero
module norm_fma16 #(
  parameter int unsigned SUMW = 24
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            sign_in,
  input  logic [SUMW-1:0] sum_in,
  input  logic [6:0]      exp_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            sign,
  output logic [9:0]      frac,
  output logic [4:0]      ex,
  output logic            g,
  output logic            r,
  output logic            t,
  output logic            of,
  output logic            zero
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [SUMW-1:0]    s_q, s_d;
  logic signed [7:0]  e_q, e_d;
  logic               sk_q, sk_d;
  logic               sign_q, sign_d;
  logic               out_valid_q, out_valid_d;
  logic [9:0]         frac_q;
  logic [4:0]         ex_q;
  logic               g_q, r_q, t_q, of_q, zero_q;
  logic               load_res, load_zero;
  logic               tail_or;
  logic               ovf;

  // Bits below the round position fold into sticky; none exist at the minimum width.
  if (SUMW > 14) begin : g_tail
    assign tail_or = |s_q[SUMW-15:0];
  end else begin : g_no_tail
    assign tail_or = 1'b0;
  end

  assign ovf = (e_q >= 8'sd31);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    e_d       = e_q;
    sk_d      = sk_q;
    sign_d    = sign_q;
    load_res  = 1'b0;
    load_zero = 1'b0;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          s_d    = sum_in;
          e_d    = {exp_in[6], exp_in};
          sk_d   = 1'b0;
          sign_d = sign_in;
          if (sum_in == '0) begin
            state_d   = StDone;
            load_zero = 1'b1;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        if (e_q < 8'sd1 || s_q[SUMW-1]) begin
          // Denormalize or fix carry-out; the shifted-out bit is kept in sticky.
          s_d  = s_q >> 1;
          sk_d = sk_q | s_q[0];
          e_d  = e_q + 8'sd1;
        end else if (!s_q[SUMW-2] && e_q > 8'sd1) begin
          s_d = s_q << 1;
          e_d = e_q - 8'sd1;
        end else begin
          state_d  = StDone;
          load_res = 1'b1;
        end
      end
      StDone: begin
        if (out_valid_q && out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // out_valid trails DONE entry by one cycle, after the result registers have loaded.
  assign out_valid_d = (state_q == StDone) && !(out_valid_q && out_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      s_q         <= '0;
      e_q         <= '0;
      sk_q        <= 1'b0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      frac_q      <= '0;
      ex_q        <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      t_q         <= 1'b0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      e_q         <= e_d;
      sk_q        <= sk_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      if (load_zero) begin
        frac_q <= '0;
        ex_q   <= '0;
        g_q    <= 1'b0;
        r_q    <= 1'b0;
        t_q    <= 1'b0;
        of_q   <= 1'b0;
        zero_q <= 1'b1;
      end else if (load_res) begin
        zero_q <= 1'b0;
        of_q   <= ovf;
        if (ovf) begin
          frac_q <= '0;
          ex_q   <= 5'd31;
          g_q    <= 1'b0;
          r_q    <= 1'b0;
          t_q    <= 1'b0;
        end else begin
          frac_q <= s_q[SUMW-3:SUMW-12];
          // Without the integer bit the value is subnormal and E has settled at 1.
          ex_q   <= s_q[SUMW-2] ? e_q[4:0] : 5'd0;
          g_q    <= s_q[SUMW-13];
          r_q    <= s_q[SUMW-14];
          t_q    <= tail_or | sk_q;
        end
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign frac      = frac_q;
  assign ex        = ex_q;
  assign g         = g_q;
  assign r         = r_q;
  assign t         = t_q;
  assign of        = of_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_norm_fma16.sv
module tb_norm_fma16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, sign_in;
  logic [23:0] sum_in;
  logic [6:0]  exp_in;
  logic        out_valid, out_ready;
  logic        sign, g, r, t, of, zero;
  logic [9:0]  frac;
  logic [4:0]  ex;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  norm_fma16 #(.SUMW(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .sum_in    (sum_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign      (sign),
    .frac      (frac),
    .ex        (ex),
    .g         (g),
    .r         (r),
    .t         (t),
    .of        (of),
    .zero      (zero)
  );

  // Result packing: {sign, of, zero, ex[4:0], frac[9:0], g, r, t}
  function automatic logic [20:0] mk(input logic s, input logic o, input logic z,
                                     input logic [4:0] e, input logic [9:0] f,
                                     input logic gg, input logic rr, input logic tt);
    return {s, o, z, e, f, gg, rr, tt};
  endfunction

  function automatic logic [20:0] observed();
    return {sign, of, zero, ex, frac, g, r, t};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = sum * 2^(exp-15). Place the leading one at weight 1 with exponent
  // max(true exponent, 1); anything shifted off the right end becomes sticky.
  task automatic model(input logic s, input logic [23:0] sm, input logic [6:0] e7,
                       output logic [20:0] res, output int lat);
    int e, p, en, ef, sh, d;
    logic [63:0] s64, al;
    logic stk;
    e = int'($signed(e7));
    if (sm == 24'd0) begin
      res = mk(s, 1'b0, 1'b1, 5'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 24; i++) if (sm[i]) p = i;
    en = e + p - 22;
    ef = (en >= 1) ? en : 1;
    sh = (p - 22) + (ef - en);
    s64 = 64'(sm);
    if (sh < 0) begin
      al = s64 << (-sh);
      stk = 1'b0;
    end else if (sh >= 24) begin
      al = 64'd0;
      stk = 1'b1;
    end else begin
      al = s64 >> sh;
      stk = (s64 & ((64'd1 << sh) - 64'd1)) != 64'd0;
    end
    if (en >= 31)
      res = mk(s, 1'b1, 1'b0, 5'd31, 10'd0, 1'b0, 1'b0, 1'b0);
    else
      res = mk(s, 1'b0, 1'b0, (en >= 1) ? 5'(en) : 5'd0, al[21:12], al[11], al[10],
               (|al[9:0]) | stk);
    d = ef - e;
    if (d < 0) d = -d;
    lat = 2 + d;
  endtask

  task automatic run_txn(input string tag, input logic s, input logic [23:0] sm,
                         input logic [6:0] e7, input logic [20:0] xres, input int xlat,
                         input int hold);
    int cyc;
    bit seen;
    check({tag, " in_ready before"}, 64'(in_ready), 64'd1);
    sign_in  = s;
    sum_in   = sm;
    exp_in   = e7;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    sum_in = '0;
    exp_in = '0;
    sign_in = 1'b0;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) cyc = -1;
    check({tag, " latency"}, 64'(cyc), 64'(xlat));
    check({tag, " result"}, 64'(observed()), 64'(xres));
    check({tag, " in_ready in done"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " held"}, 64'({out_valid, in_ready, observed()}), 64'({2'b10, xres}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, " after handshake"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [20:0] xr;
    int          xl;
    int          w;
    logic [23:0] mask, sm;
    logic [6:0]  e7;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    sign_in   = 1'b0;
    sum_in    = '0;
    exp_in    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset state", 64'({in_ready, out_valid, observed()}), 64'({2'b10, 21'd0}));
    reset_n = 1'b1;
    @(negedge clk);

    run_txn("normalized", 1'b0, 24'h400000, 7'd15, mk(0, 0, 0, 5'd15, 10'd0, 0, 0, 0), 2, 0);
    run_txn("right+sticky", 1'b0, 24'h800001, 7'd15, mk(0, 0, 0, 5'd16, 10'd0, 0, 0, 1), 3, 0);
    run_txn("left", 1'b0, 24'h000800, 7'd20, mk(0, 0, 0, 5'd9, 10'd0, 0, 0, 0), 13, 0);
    run_txn("subnormal", 1'b0, 24'h400000, 7'd0, mk(0, 0, 0, 5'd0, 10'h200, 0, 0, 0), 3, 0);
    run_txn("deep subnormal", 1'b0, 24'h400000, 7'h74, mk(0, 0, 0, 5'd0, 10'd0, 0, 0, 1), 15,
            0);
    run_txn("overflow", 1'b0, 24'h800000, 7'd30, mk(0, 1, 0, 5'd31, 10'd0, 0, 0, 0), 3, 0);
    run_txn("zero", 1'b1, 24'h000000, 7'd5, mk(1, 0, 1, 5'd0, 10'd0, 0, 0, 0), 1, 0);
    run_txn("backpressure", 1'b1, 24'h400000, 7'd15, mk(1, 0, 0, 5'd15, 10'd0, 0, 0, 0), 2, 5);

    // Reset in the middle of a long left-normalization.
    sign_in  = 1'b0;
    sum_in   = 24'h000800;
    exp_in   = 7'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("reset mid-shift", 64'({in_ready, out_valid}), 64'b10);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no output after reset", 64'({in_ready, out_valid}), 64'b10);
    run_txn("after reset", 1'b0, 24'h400000, 7'd15, mk(0, 0, 0, 5'd15, 10'd0, 0, 0, 0), 2, 0);

    for (int n = 0; n < 40; n++) begin
      w    = $urandom_range(0, 24);
      mask = (24'h1 << w) - 24'h1;
      sm   = 24'($urandom) & mask;
      e7   = 7'($urandom);
      model(1'($urandom), sm, e7, xr, xl);
      run_txn("random", xr[20], sm, e7, xr, xl, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
